// File: rtl/noc_route_pkg.sv
// Shared helpers for the hypercube route stage: codeword sizing, Hamming syndrome, set-bit search.
package noc_route_pkg;

    // Largest supported parity width and the matching codeword / address bounds for the helpers.
    localparam int unsigned MAX_PAR_W  = 8;
    localparam int unsigned MAX_CODE_W = (1 << MAX_PAR_W) - 1;
    localparam int unsigned MAX_ADDR_W = 32;

    // Default router dimension; the core port always sits just above the router ports.
    localparam int unsigned DEFAULT_ADDR_W = 4;
    localparam int unsigned CORE_PORT      = DEFAULT_ADDR_W;

    // Codeword width for a Hamming code with par_w parity bits.
    function automatic int unsigned code_width(input int unsigned par_w);
        return (32'd1 << par_w) - 32'd1;
    endfunction

    // Syndrome: XOR of the 1-based positions of every set bit (unused upper bits are zero).
    function automatic logic [MAX_PAR_W-1:0] calc_syndrome(input logic [MAX_CODE_W-1:0] code);
        logic [MAX_PAR_W-1:0] s;
        s = '0;
        for (int j = 0; j < MAX_CODE_W; j++) begin
            if (code[j]) begin
                s = s ^ MAX_PAR_W'(j + 1);
            end
        end
        return s;
    endfunction

    // Index of the lowest set bit; -1 when x is zero.
    function automatic int lowest_set_idx(input logic [MAX_ADDR_W-1:0] x);
        int idx;
        idx = -1;
        for (int i = MAX_ADDR_W - 1; i >= 0; i--) begin
            if (x[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Index of the highest set bit; -1 when x is zero.
    function automatic int highest_set_idx(input logic [MAX_ADDR_W-1:0] x);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (x[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hamming_correct.sv
// Combinational single-error Hamming corrector; also usable at the core network interface.
module hamming_correct
    import noc_route_pkg::*;
#(
    parameter int unsigned PAR_W = 3,
    localparam int unsigned CODE_W = code_width(PAR_W)
) (
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] code_out,
    output logic [PAR_W-1:0]  syndrome
);

    // Syndrome names the 1-based position of a single flipped bit, zero when clean.
    assign syndrome = PAR_W'(calc_syndrome(MAX_CODE_W'(code_in)));

    // Flip the bit the syndrome points at; a nonzero syndrome always lands inside the word.
    always_comb begin
        code_out = code_in;
        for (int j = 0; j < int'(CODE_W); j++) begin
            if (syndrome == PAR_W'(j + 1)) begin
                code_out[j] = ~code_in[j];
            end
        end
    end

endmodule

// File: rtl/hypercube_route_stage.sv
// Hypercube route stage: ECC-correct the flit, pick an output dimension, hold it in a one-entry register.
module hypercube_route_stage
    import noc_route_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 4,
    parameter logic [ADDR_W-1:0]  NODE_ADDR = '0,
    parameter int unsigned        PAR_W     = 3,
    parameter int unsigned        ID        = 0,
    parameter int unsigned        ID_W      = 3,
    parameter int unsigned        CNT_W     = 8,
    localparam int unsigned       CODE_W    = code_width(PAR_W),
    localparam int unsigned       FLIT_W    = CODE_W + ADDR_W,
    localparam int unsigned       SEL_W     = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              mode_msb_first,
    output logic [SEL_W-1:0]  out_valid,
    input  logic [SEL_W-1:0]  out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic [ID_W-1:0]   out_src_id,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag
);

    localparam int unsigned CORE_BIT = ADDR_W;

    logic              ready_en;
    logic              held_c;
    logic              xfer_c;
    logic              accept_c;
    logic [ADDR_W-1:0] dest_c;
    logic [ADDR_W-1:0] diff_c;
    logic [CODE_W-1:0] code_fix_c;
    logic [PAR_W-1:0]  syn_c;
    int                dim_c;
    logic [SEL_W-1:0]  sel_c;

    // Correct the incoming codeword before it is registered.
    hamming_correct #(
        .PAR_W (PAR_W)
    ) u_ecc (
        .code_in  (in_flit[FLIT_W-1:ADDR_W]),
        .code_out (code_fix_c),
        .syndrome (syn_c)
    );

    // Handshake: the register frees up in the same cycle its flit is taken.
    assign held_c   = |out_valid;
    assign xfer_c   = |(out_valid & out_ready);
    assign in_ready = ready_en && (!held_c || xfer_c);
    assign accept_c = in_valid && in_ready;

    // Differing dimensions between destination and this node.
    assign dest_c = in_flit[ADDR_W-1:0];
    assign diff_c = dest_c ^ NODE_ADDR;

    // Dimension order chosen per flit at accept time.
    always_comb begin
        if (mode_msb_first) begin
            dim_c = highest_set_idx(MAX_ADDR_W'(diff_c));
        end else begin
            dim_c = lowest_set_idx(MAX_ADDR_W'(diff_c));
        end
    end

    // One-hot destination: core when already home, else the chosen dimension's port.
    always_comb begin
        sel_c = '0;
        if (diff_c == '0) begin
            sel_c[CORE_BIT] = 1'b1;
        end else begin
            for (int k = 0; k < int'(ADDR_W); k++) begin
                if (dim_c == k) begin
                    sel_c[k] = 1'b1;
                end
            end
        end
    end

    // Pipeline register plus error statistics; ready only comes up one edge after reset drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            out_valid  <= '0;
            out_flit   <= '0;
            out_src_id <= '0;
            err_count  <= '0;
            err_flag   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept_c) begin
                out_valid  <= sel_c;
                out_flit   <= {code_fix_c, dest_c};
                out_src_id <= ID_W'(ID);
            end else if (xfer_c) begin
                out_valid <= '0;
            end
            if (accept_c && (syn_c != '0)) begin
                err_flag <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hypercube_route_stage.sv
// Bench for hypercube_route_stage: directed cases then randomized traffic against a behavioural model.
module tb_hypercube_route_stage;

    localparam logic [3:0] NODE = 4'b0000;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [10:0] in_flit;
    logic        mode_msb_first;
    logic [4:0]  out_ready;

    logic        in_ready,  in_ready2;
    logic [4:0]  out_valid, out_valid2;
    logic [10:0] out_flit,  out_flit2;
    logic [2:0]  out_src_id, out_src_id2;
    logic [7:0]  err_count;
    logic [1:0]  err_count2;
    logic        err_flag,  err_flag2;

    int n_cmp;
    int n_err;

    // Model state
    logic [4:0]  m_valid;
    logic [10:0] m_flit;
    int          m_cnt;
    logic        m_flag;
    logic        m_en;

    hypercube_route_stage #(
        .ADDR_W(4), .NODE_ADDR(NODE), .PAR_W(3), .ID(5), .ID_W(3), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .mode_msb_first(mode_msb_first), .out_valid(out_valid),
        .out_ready(out_ready), .out_flit(out_flit), .out_src_id(out_src_id),
        .err_count(err_count), .err_flag(err_flag)
    );

    hypercube_route_stage #(
        .ADDR_W(4), .NODE_ADDR(NODE), .PAR_W(3), .ID(2), .ID_W(3), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_flit(in_flit), .mode_msb_first(mode_msb_first), .out_valid(out_valid2),
        .out_ready(out_ready), .out_flit(out_flit2), .out_src_id(out_src_id2),
        .err_count(err_count2), .err_flag(err_flag2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_syndrome(input logic [6:0] cw);
        int s;
        s = 0;
        for (int p = 1; p <= 7; p++) begin
            if (cw[p-1]) s = s ^ p;
        end
        return s;
    endfunction

    function automatic logic [6:0] ref_fix(input logic [6:0] cw);
        int s;
        s = ref_syndrome(cw);
        if (s != 0) return cw ^ (7'(1) << (s - 1));
        return cw;
    endfunction

    function automatic logic [4:0] ref_route(input logic [3:0] dest, input logic md);
        int unsigned x, v, h;
        x = 32'(dest ^ NODE);
        if (x == 0) return 5'b10000;
        if (!md) x = x & (~x + 32'd1);
        v = x;
        h = 0;
        while (v > 1) begin
            v = v >> 1;
            h++;
        end
        return 5'(32'd1 << h);
    endfunction

    task automatic model_clear();
        m_valid = '0;
        m_flit  = '0;
        m_cnt   = 0;
        m_flag  = 1'b0;
        m_en    = 1'b0;
    endtask

    // One clock: drive inputs, check registered outputs and ready, then advance the model.
    task automatic cycle(input logic iv, input logic [10:0] f, input logic md,
                         input logic [4:0] ordy, output logic acc);
        logic xfer;
        logic exp_rdy;
        in_valid = iv;
        in_flit = f;
        mode_msb_first = md;
        out_ready = ordy;
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_valid2", 32'(out_valid2), 32'(m_valid));
        if (m_valid != 0) begin
            check_eq("out_flit", 32'(out_flit), 32'(m_flit));
            check_eq("out_src_id", 32'(out_src_id), 32'd5);
            check_eq("out_src_id2", 32'(out_src_id2), 32'd2);
        end
        check_eq("err_count", 32'(err_count), 32'(m_cnt));
        check_eq("err_count_sat", 32'(err_count2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
        check_eq("err_flag", 32'(err_flag), 32'(m_flag));
        xfer = (m_valid & ordy) != 0;
        exp_rdy = m_en && ((m_valid == 0) || xfer);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("in_ready2", 32'(in_ready2), 32'(exp_rdy));
        acc = iv && exp_rdy;
        if (acc) begin
            m_valid = ref_route(f[3:0], md);
            m_flit = {ref_fix(f[10:4]), f[3:0]};
            if (ref_syndrome(f[10:4]) != 0) begin
                m_flag = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (xfer) begin
            m_valid = '0;
        end
        m_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_flit", 32'(out_flit), 32'd0);
        check_eq("rst_src_id", 32'(out_src_id), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_err_flag", 32'(err_flag), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic a;
        logic [10:0] held_flit;
        logic have;
        logic [10:0] pf;
        logic pm;
        logic [6:0] cw;
        logic [4:0] ordy;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_flit = '0;
        mode_msb_first = 1'b0;
        out_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;

        // Directed cases
        cycle(1'b0, '0, 1'b0, 5'b11111, a);
        cycle(1'b1, {7'b1010101, 4'b0110}, 1'b0, 5'b11111, a);
        check_eq("tp_port1", 32'(out_valid), 32'b00010);
        check_eq("tp_clean_flit", 32'(out_flit), 32'({7'b1010101, 4'b0110}));
        check_eq("tp_clean_cnt", 32'(err_count), 32'd0);
        cycle(1'b1, {7'b1010001, 4'b0110}, 1'b0, 5'b11111, a);
        check_eq("tp_fixed_flit", 32'(out_flit), 32'({7'b1010101, 4'b0110}));
        check_eq("tp_fixed_cnt", 32'(err_count), 32'd1);
        check_eq("tp_fixed_flag", 32'(err_flag), 32'd1);
        cycle(1'b1, {7'b1010101, 4'b0110}, 1'b1, 5'b11111, a);
        check_eq("tp_msb_port2", 32'(out_valid), 32'b00100);
        cycle(1'b1, {7'b1010101, 4'b0000}, 1'b0, 5'b11111, a);
        check_eq("tp_core", 32'(out_valid), 32'b10000);

        // Stall port 1 with a second flit waiting
        cycle(1'b1, {7'b0110011, 4'b0010}, 1'b0, 5'b11101, a);
        held_flit = out_flit;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, {7'b1111111, 4'b0001}, 1'b1, 5'b11101, a);
            check_eq("stall_flit", 32'(out_flit), 32'(held_flit));
            check_eq("stall_ready", 32'(in_ready), 32'd0);
        end
        cycle(1'b1, {7'b1111111, 4'b0001}, 1'b1, 5'b11111, a);
        check_eq("stall_release", 32'(out_valid), 32'b00001);

        // Reset during a stall
        cycle(1'b1, {7'b0000000, 4'b0010}, 1'b0, 5'b11101, a);
        cycle(1'b0, '0, 1'b0, 5'b11101, a);
        reset = 1'b1;
        #1;
        check_reset_state();
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized traffic; the sender holds a flit until it is accepted
        have = 1'b0;
        pf = '0;
        pm = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!have && ($urandom_range(0, 3) != 0)) begin
                cw = 7'($urandom);
                if ($urandom_range(0, 1) == 0) cw = ref_fix(cw);
                pf = {cw, 4'($urandom)};
                pm = 1'($urandom);
                have = 1'b1;
            end
            for (int b = 0; b < 5; b++) ordy[b] = ($urandom_range(0, 9) < 7);
            cycle(have, pf, have ? pm : 1'($urandom), ordy, a);
            if (a) have = 1'b0;
        end
        check_eq("final_sat", 32'(err_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hypercube_route_stage.md
Name: hypercube_route_stage

Overview:
- Clocked, parametrised successor to the CSP path-computation and split pair of the NoC router.
- Accepts one flit per handshake and corrects a single-bit error in the Hamming-coded payload.
- Computes the hypercube output dimension from destination XOR local address, then steers the flit to one of ADDR_W router ports or the local core through a one-entry pipeline register.
- Adds what the CSP version lacks: selectable dimension order, back-pressure per output, and error statistics.

Parameters:
- ADDR_W, 4: address bits, which is also the hypercube dimension and the router port count.
- NODE_ADDR, 4'b0000: local node address, ADDR_W bits.
- PAR_W, 3: Hamming parity bits; codeword width CODE_W = 2^PAR_W - 1 (7 by default).
- ID, 0: local router ID, driven on out_src_id with every flit.
- ID_W, 3: width of out_src_id.
- CNT_W, 8: width of the corrected-error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input can be accepted this cycle.
- in_flit  in  CODE_W+ADDR_W  {codeword, dest_addr}; dest_addr occupies bits [ADDR_W-1:0].
- mode_msb_first  in  1  0 = lowest differing dimension first; 1 = highest first. Sampled at accept.
- out_valid  out  ADDR_W+1  one-hot; bit k<ADDR_W selects router port k, bit ADDR_W selects the core.
- out_ready  in  ADDR_W+1  per-destination ready.
- out_flit  out  CODE_W+ADDR_W  {corrected codeword, dest_addr}.
- out_src_id  out  ID_W  equals ID whenever out_valid != 0.
- err_count  out  CNT_W  count of corrected flits; saturates at all-ones.
- err_flag  out  1  sticky; set by the first corrected flit.

Behaviour:
- Reset (async, any cycle): out_valid=0, out_flit=0, out_src_id=0, err_count=0, err_flag=0, held entry discarded. in_ready=1 from the first edge after reset deasserts.
- Handshake rules:
  - Accept occurs when in_valid && in_ready.
  - Transfer occurs when (out_valid & out_ready) != 0.
  - in_ready = !held || transfer; back-to-back flits stream at one per cycle.
  - Once out_valid is asserted, out_flit and the one-hot selection stay stable until transfer.
- Latency: an accepted flit appears on outputs in the next cycle.
- ECC decode (combinational, on the input flit):
  - Codeword bit j corresponds to position j+1.
  - Syndrome s = XOR of (j+1) over all j where bit j = 1.
  - If s != 0, invert bit s-1.
  - s is always at most CODE_W, so there is no out-of-range case.
  - Double-bit errors are miscorrected silently; this is not detected by design.
- Routing:
  - x = dest_addr ^ NODE_ADDR.
  - x == 0: select core bit ADDR_W.
  - Otherwise, mode 0 selects the lowest set bit index of x; mode 1 selects the highest.
  - dest_addr is forwarded unmodified.
- Statistics, updated on accept with s != 0:
  - err_count increments and saturates; it does not wrap.
  - err_flag is set and only reset clears it.
- Boundary cases:
  - Accept and transfer in the same cycle: the register loads the new flit with no bubble.
  - Output stalled: in_ready=0 and the input is held by the sender.
  - out_ready bits for unselected ports are ignored.
  - mode_msb_first changing while a flit is held does not affect that flit.

Decomposition:
- Shared package noc_route_pkg:
  - CODE_W derivation function.
  - Function to compute the syndrome.
  - Lowest/highest set-bit index functions.
  - Constant CORE_PORT = ADDR_W.
- One sub-module, hamming_correct:
  - Combinational, parametrised by PAR_W.
  - Outputs the corrected codeword and the syndrome.
  - Reusable at the core network interface.

Test Plan:
- NODE_ADDR=0000, mode 0, in_flit={7'b1010101,4'b0110}, all ready → next cycle out_valid=00010 (port 1), out_flit unchanged, err_count=0.
- Same flit with codeword bit 2 flipped (7'b1010001) → out_flit codeword 7'b1010101, err_count=1, err_flag=1.
- dest 0110 with mode 1 → out_valid=00100 (port 2); dest 0000 → out_valid=10000 (core).
- Port 1 out_ready held low for 3 cycles with two flits queued → in_ready=0, out_flit stable for 3 cycles, then the second flit follows with no bubble.
- CNT_W=2, five corrupted flits → err_count reads 1,2,3,3,3.
- Reset asserted mid-stall with out_valid=00010 → out_valid=0 immediately (async), err_count=0, held flit lost.
